// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared main-memory port between I-fill, D-fill and D write-through
// and stalls the pipeline while a transaction is pending. `ARB_STALL_CNT_EN adds stall_cycles.
module cache_mem_arbiter #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_miss,
    input  logic [ADDR_W-1:0]              i_miss_addr,
    input  logic                           d_miss,
    input  logic [ADDR_W-1:0]              d_miss_addr,
    input  logic                           d_wr_req,
    input  logic [ADDR_W-1:0]              d_wr_addr,
    input  logic [DATA_W-1:0]              d_wr_data,
    input  logic                           mem_data_valid,
    output logic                           mem_en,
    output logic                           mem_wr,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    output logic                           i_fill_we,
    output logic                           d_fill_we,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx,
    output logic                           i_fill_done,
    output logic                           d_fill_done,
    output logic                           d_wr_ack,
    output logic                           pipe_wen,
    output logic                           busy
`ifdef ARB_STALL_CNT_EN
    ,
    output logic [15:0]                    stall_cycles
`endif
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam logic [IDX_W:0]      BW_CNT   = (IDX_W+1)'(BLOCK_WORDS);
    localparam logic [IDX_W-1:0]    LAST_RET = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0]   OFF_MASK = ADDR_W'(2 * BLOCK_WORDS - 1);

    typedef enum logic [2:0] {IDLE, WRITE, IFILL, DFILL, IDONE, DDONE} state_t;

    state_t              state_q, state_d;
    logic [IDX_W:0]      iss_q, iss_d;
    logic [IDX_W-1:0]    ret_q, ret_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;

    // Requests are levels held by the requester until its done/ack pulse;
    // the arbiter samples them only in IDLE, so later drops or address changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            iss_q     <= '0;
            ret_q     <= '0;
            base_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            iss_q     <= iss_d;
            ret_q     <= ret_d;
            base_q    <= base_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        iss_d         = iss_q;
        ret_d         = ret_q;
        base_d        = base_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        mem_en        = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        i_fill_we     = 1'b0;
        d_fill_we     = 1'b0;
        fill_word_idx = '0;
        i_fill_done   = 1'b0;
        d_fill_done   = 1'b0;
        d_wr_ack      = 1'b0;
        case (state_q)
            IDLE: begin
                iss_d = '0;
                ret_d = '0;
                if (d_wr_req) begin
                    state_d   = WRITE;
                    wr_addr_d = d_wr_addr;
                    wr_data_d = d_wr_data;
                end else if (d_miss) begin
                    state_d = DFILL;
                    base_d  = d_miss_addr & ~OFF_MASK;
                end else if (i_miss) begin
                    state_d = IFILL;
                    base_d  = i_miss_addr & ~OFF_MASK;
                end
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = wr_addr_q;
                mem_wdata = wr_data_q;
                d_wr_ack  = 1'b1;
                state_d   = IDLE;
            end
            IFILL, DFILL: begin
                // Issue runs ahead of returns; the pipelined memory accepts one read per cycle.
                if (iss_q < BW_CNT) begin
                    mem_en   = 1'b1;
                    mem_addr = base_q + ADDR_W'({iss_q, 1'b0});
                    iss_d    = iss_q + 1'b1;
                end
                fill_word_idx = ret_q;
                if (mem_data_valid) begin
                    i_fill_we = (state_q == IFILL);
                    d_fill_we = (state_q == DFILL);
                    ret_d     = ret_q + 1'b1;
                    if (ret_q == LAST_RET) begin
                        state_d = (state_q == IFILL) ? IDONE : DDONE;
                    end
                end
            end
            IDONE: begin
                i_fill_done = 1'b1;
                state_d     = IDLE;
            end
            DDONE: begin
                d_fill_done = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pipe_wen = (state_q == IDLE) & ~i_miss & ~d_miss & ~d_wr_req;
    assign busy     = (state_q != IDLE);

`ifdef ARB_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (!pipe_wen && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a 4-cycle pipelined memory model;
// the stall counter scenario is built only when ARB_STALL_CNT_EN is defined.
module tb_cache_mem_arbiter;

    logic        clk, rst_n;
    logic        i_miss, d_miss, d_wr_req, mem_data_valid;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
    logic        mem_en, mem_wr, i_fill_we, d_fill_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [2:0]  fill_word_idx;
    logic        i_fill_done, d_fill_done, d_wr_ack, pipe_wen, busy;
`ifdef ARB_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [3:0] lat_sr;
    logic       mute, inject;

    cache_mem_arbiter #(.BLOCK_WORDS(8), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_data_valid(mem_data_valid),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we), .fill_word_idx(fill_word_idx),
        .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .d_wr_ack(d_wr_ack),
        .pipe_wen(pipe_wen), .busy(busy)
`ifdef ARB_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Read issued in cycle c returns data in cycle c+4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lat_sr <= '0;
        else        lat_sr <= {lat_sr[2:0], mem_en & ~mem_wr};
    end
    assign mem_data_valid = (lat_sr[3] & ~mute) | inject;

    task automatic test_reset();
        rst_n = 1'b0; i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
        i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
        mute = 1'b0; inject = 1'b0;
        #1;
        vec_cnt++;
        if ({mem_en, mem_wr, mem_addr, mem_wdata, i_fill_we, d_fill_we, fill_word_idx,
             i_fill_done, d_fill_done, d_wr_ack, busy} !== '0) begin
            err_cnt++; $display("FAIL reset_outputs got en=%b addr=%h busy=%b exp all 0", mem_en, mem_addr, busy);
        end
        vec_cnt++;
        if (pipe_wen !== 1'b1) begin err_cnt++; $display("FAIL reset_pipe_wen got %b exp 1", pipe_wen); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b0 || pipe_wen !== 1'b1) begin
            err_cnt++; $display("FAIL post_reset_idle got busy=%b wen=%b exp 0/1", busy, pipe_wen);
        end
    endtask

    task automatic test_stray_valid();
        @(negedge clk);
        inject = 1'b1;
        #1;
        vec_cnt++;
        if (i_fill_we !== 1'b0 || d_fill_we !== 1'b0) begin
            err_cnt++; $display("FAIL stray_valid_we got i=%b d=%b exp 0/0", i_fill_we, d_fill_we);
        end
        @(negedge clk);
        inject = 1'b0;
        vec_cnt++;
        if (busy !== 1'b0) begin err_cnt++; $display("FAIL stray_valid_busy got %b exp 0", busy); end
    endtask

    task automatic test_ifill();
        int n_iss, n_ret, done_cyc, last_ret;
        n_iss = 0; n_ret = 0; done_cyc = -1; last_ret = -1;
        @(negedge clk);
        i_miss = 1'b1; i_miss_addr = 16'h1236;
        #1;
        vec_cnt++;
        if (pipe_wen !== 1'b0) begin err_cnt++; $display("FAIL ifill_stall_start got %b exp 0", pipe_wen); end
        for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            vec_cnt++;
            if (pipe_wen !== 1'b0) begin err_cnt++; $display("FAIL ifill_stall cyc %0d got %b exp 0", cyc, pipe_wen); end
            if (mem_en) begin
                vec_cnt++;
                if (mem_wr !== 1'b0 || mem_addr !== 16'h1230 + 16'(2 * n_iss) || cyc != n_iss + 1) begin
                    err_cnt++; $display("FAIL ifill_issue cyc %0d got wr=%b addr=%h exp wr=0 addr=%h cyc %0d",
                                        cyc, mem_wr, mem_addr, 16'h1230 + 16'(2 * n_iss), n_iss + 1);
                end
                n_iss++;
            end
            if (i_fill_we) begin
                vec_cnt++;
                if (fill_word_idx !== 3'(n_ret)) begin
                    err_cnt++; $display("FAIL ifill_idx got %0d exp %0d", fill_word_idx, n_ret);
                end
                n_ret++; last_ret = cyc;
            end
            vec_cnt++;
            if (d_fill_we !== 1'b0) begin err_cnt++; $display("FAIL ifill_dwe cyc %0d got 1 exp 0", cyc); end
            if (i_fill_done) begin done_cyc = cyc; i_miss = 1'b0; end
        end
        vec_cnt++;
        if (n_iss != 8 || n_ret != 8) begin err_cnt++; $display("FAIL ifill_counts got iss=%0d ret=%0d exp 8/8", n_iss, n_ret); end
        vec_cnt++;
        if (done_cyc != 13 || last_ret != 12) begin
            err_cnt++; $display("FAIL ifill_done_cyc got done=%0d last=%0d exp 13/12", done_cyc, last_ret);
        end
        @(negedge clk);
        vec_cnt++;
        if (pipe_wen !== 1'b1 || busy !== 1'b0) begin
            err_cnt++; $display("FAIL ifill_release got wen=%b busy=%b exp 1/0", pipe_wen, busy);
        end
    endtask

    task automatic test_dual();
        int d_done, i_done, d_we, i_we, i_we_early, first_i, n_d_iss;
        d_done = -1; i_done = -1; d_we = 0; i_we = 0; i_we_early = 0; first_i = -1; n_d_iss = 0;
        @(negedge clk);
        d_miss = 1'b1; d_miss_addr = 16'h4008; i_miss = 1'b1; i_miss_addr = 16'h2002;
        for (int cyc = 1; cyc <= 80 && i_done < 0; cyc++) begin
            @(negedge clk);
            if (mem_en && d_done < 0) begin
                vec_cnt++;
                if (mem_addr !== 16'h4000 + 16'(2 * n_d_iss)) begin
                    err_cnt++; $display("FAIL dual_daddr got %h exp %h", mem_addr, 16'h4000 + 16'(2 * n_d_iss));
                end
                n_d_iss++;
            end
            if (mem_en && d_done >= 0 && first_i < 0) begin
                first_i = cyc;
                vec_cnt++;
                if (mem_addr !== 16'h2000) begin err_cnt++; $display("FAIL dual_iaddr got %h exp 2000", mem_addr); end
            end
            if (d_fill_we) d_we++;
            if (i_fill_we) begin
                if (d_done < 0) i_we_early++;
                else            i_we++;
            end
            if (d_fill_done) begin d_done = cyc; d_miss = 1'b0; end
            if (i_fill_done) begin i_done = cyc; i_miss = 1'b0; end
        end
        vec_cnt++;
        if (d_done != 13) begin err_cnt++; $display("FAIL dual_d_done got %0d exp 13", d_done); end
        vec_cnt++;
        if (i_we_early != 0) begin err_cnt++; $display("FAIL dual_ifill_we_in_dfill got %0d exp 0", i_we_early); end
        vec_cnt++;
        if (d_we != 8 || i_we != 8) begin err_cnt++; $display("FAIL dual_we_counts got d=%0d i=%0d exp 8/8", d_we, i_we); end
        vec_cnt++;
        if (first_i != 15 || i_done != 27) begin
            err_cnt++; $display("FAIL dual_i_timing got first=%0d done=%0d exp 15/27", first_i, i_done);
        end
        @(negedge clk);
    endtask

    task automatic test_write();
        @(negedge clk);
        d_wr_req = 1'b1; d_wr_addr = 16'h0010; d_wr_data = 16'hBEEF;
        @(negedge clk);
        vec_cnt++;
        if ({mem_en, mem_wr, d_wr_ack, busy, pipe_wen} !== 5'b11110 || mem_addr !== 16'h0010 || mem_wdata !== 16'hBEEF) begin
            err_cnt++; $display("FAIL write_cycle got en=%b wr=%b ack=%b addr=%h data=%h exp 1/1/1 0010 BEEF",
                                mem_en, mem_wr, d_wr_ack, mem_addr, mem_wdata);
        end
        d_wr_req = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({mem_en, d_wr_ack, busy, pipe_wen} !== 4'b0001) begin
            err_cnt++; $display("FAIL write_idle got en=%b ack=%b busy=%b wen=%b exp 0/0/0/1", mem_en, d_wr_ack, busy, pipe_wen);
        end
    endtask

    task automatic test_wr_miss();
        int acks, ack_cyc, first_rd, d_done;
        acks = 0; ack_cyc = -1; first_rd = -1; d_done = -1;
        @(negedge clk);
        d_wr_req = 1'b1; d_wr_addr = 16'h0020; d_wr_data = 16'h1234;
        d_miss = 1'b1; d_miss_addr = 16'h0A0C;
        for (int cyc = 1; cyc <= 40 && d_done < 0; cyc++) begin
            @(negedge clk);
            if (d_wr_ack) begin
                acks++; ack_cyc = cyc; d_wr_req = 1'b0;
                vec_cnt++;
                if (mem_addr !== 16'h0020 || mem_wdata !== 16'h1234) begin
                    err_cnt++; $display("FAIL wrmiss_write got addr=%h data=%h exp 0020 1234", mem_addr, mem_wdata);
                end
            end
            if (mem_en && !mem_wr && first_rd < 0) begin
                first_rd = cyc;
                vec_cnt++;
                if (mem_addr !== 16'h0A00) begin err_cnt++; $display("FAIL wrmiss_base got %h exp 0A00", mem_addr); end
            end
            if (d_fill_done) begin d_done = cyc; d_miss = 1'b0; end
        end
        vec_cnt++;
        if (acks != 1 || ack_cyc != 1) begin err_cnt++; $display("FAIL wrmiss_ack got n=%0d cyc=%0d exp 1/1", acks, ack_cyc); end
        vec_cnt++;
        if (first_rd != 3 || d_done != 15) begin
            err_cnt++; $display("FAIL wrmiss_fill got first=%0d done=%0d exp 3/15", first_rd, d_done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n_ret, done_cyc, first_rd;
        n_ret = 0;
        @(negedge clk);
        i_miss = 1'b1; i_miss_addr = 16'h3000;
        for (int cyc = 1; cyc <= 30 && n_ret < 3; cyc++) begin
            @(negedge clk);
            if (i_fill_we) n_ret++;
        end
        vec_cnt++;
        if (n_ret != 3) begin err_cnt++; $display("FAIL rstmid_progress got %0d exp 3", n_ret); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({mem_en, mem_wr, mem_addr, mem_wdata, i_fill_we, d_fill_we, fill_word_idx,
             i_fill_done, d_fill_done, d_wr_ack, busy, pipe_wen} !== '0) begin
            err_cnt++; $display("FAIL rstmid_outputs got en=%b addr=%h idx=%0d busy=%b wen=%b exp all 0",
                                mem_en, mem_addr, fill_word_idx, busy, pipe_wen);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vec_cnt++;
            if (i_fill_done !== 1'b0 || busy !== 1'b0) begin
                err_cnt++; $display("FAIL rstmid_hold got done=%b busy=%b exp 0/0", i_fill_done, busy);
            end
        end
        rst_n = 1'b1;
        n_ret = 0; done_cyc = -1; first_rd = -1;
        for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (mem_en && first_rd < 0) begin
                first_rd = cyc;
                vec_cnt++;
                if (mem_addr !== 16'h3000) begin err_cnt++; $display("FAIL rstmid_refetch_addr got %h exp 3000", mem_addr); end
            end
            if (i_fill_we) begin
                vec_cnt++;
                if (fill_word_idx !== 3'(n_ret)) begin
                    err_cnt++; $display("FAIL rstmid_refetch_idx got %0d exp %0d", fill_word_idx, n_ret);
                end
                n_ret++;
            end
            if (i_fill_done) begin done_cyc = cyc; i_miss = 1'b0; end
        end
        vec_cnt++;
        if (first_rd != 1 || done_cyc != 13 || n_ret != 8) begin
            err_cnt++; $display("FAIL rstmid_refetch got first=%0d done=%0d ret=%0d exp 1/13/8", first_rd, done_cyc, n_ret);
        end
        @(negedge clk);
    endtask

`ifdef ARB_STALL_CNT_EN
    task automatic test_stall_cnt();
        int done_cyc;
        done_cyc = -1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (stall_cycles !== 16'd0) begin err_cnt++; $display("FAIL stall_reset got %h exp 0000", stall_cycles); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        i_miss = 1'b1; i_miss_addr = 16'h1236;
        for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (i_fill_done) begin done_cyc = cyc; i_miss = 1'b0; end
        end
        @(negedge clk);
        vec_cnt++;
        if (stall_cycles !== 16'd14) begin err_cnt++; $display("FAIL stall_fill got %0d exp 14", stall_cycles); end
        mute = 1'b1;
        i_miss = 1'b1;
        repeat (65540) @(negedge clk);
        vec_cnt++;
        if (stall_cycles !== 16'hFFFF) begin err_cnt++; $display("FAIL stall_saturate got %h exp FFFF", stall_cycles); end
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (stall_cycles !== 16'd0) begin err_cnt++; $display("FAIL stall_async_clear got %h exp 0000", stall_cycles); end
        i_miss = 1'b0; mute = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_stray_valid();
        test_ifill();
        test_dual();
        test_write();
        test_wr_miss();
        test_reset_mid();
`ifdef ARB_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
